uart_frame_sched: RTL and testbench
===================================

UART_FRAME_SCHED -- requirements
Module: uart_frame_sched

Interface
REQ-001 SHALL have parameter NCH, default 4: number of requesting channels (2..8).
REQ-002 SHALL have parameter HDR0, default 8'hAA: frame header byte 0.
REQ-003 SHALL have parameter HDR1, default 8'h07: frame header byte 1.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  NCH  per-channel frame request; level, held by requester until its ack.
REQ-007 data_in  input  16*NCH  per-channel payload; channel i at bits [16*i+15:16*i].
REQ-008 ack  output  NCH  one-cycle grant pulse; payload captured on that cycle.
REQ-009 tx_ready  input  1  byte transmitter idle and able to accept tx_start.
REQ-010 tx_done  input  1  one-cycle pulse when the byte transmitter has finished the stop bit.
REQ-011 tx_start  output  1  one-cycle pulse to launch one byte.
REQ-012 tx_byte  output  8  byte to send; valid and stable from the tx_start cycle until tx_done.
REQ-013 busy  output  1  high whenever the state is not IDLE.
REQ-014 frame_done  output  1  one-cycle pulse after the last byte's tx_done.
REQ-015 frames_sent  output  16  count of completed frames.

Function
REQ-016 Each frame SHALL be 6 bytes in order: HDR0, HDR1, channel index (8'h00..NCH-1), payload[15:8], payload[7:0], checksum.
REQ-017 The checksum SHALL be the XOR of bytes 0..4.
REQ-018 The state machine SHALL use exactly these states: IDLE, GRANT, SEND, WAIT.
REQ-019 IDLE -> GRANT SHALL occur on the first cycle on which any req bit is high; otherwise IDLE is held.
REQ-020 Arbitration SHALL be round-robin: the search starts at last_grant+1 mod NCH; the lowest-index requester in that rotated order wins.
REQ-021 In GRANT, ack[win] SHALL pulse for one cycle, the payload and index SHALL be latched, last_grant SHALL be set to win, byte index SHALL be set to 0, and the next state SHALL be SEND.
REQ-022 A req that falls before GRANT SHALL NOT be served; a req that rises during a frame SHALL be considered only on return to IDLE.
REQ-023 SEND: if tx_ready is high, tx_start SHALL pulse with tx_byte = current byte, then -> WAIT; if tx_ready is low, SEND is held and tx_start stays 0.
REQ-024 WAIT: on tx_done, if byte index = 5 -> IDLE with frame_done pulsed and frames_sent incremented; else byte index +1 -> SEND. tx_done seen in any other state SHALL be ignored.
REQ-025 Minimum gap from GRANT to the first tx_start SHALL be 1 cycle (GRANT, then SEND with tx_ready high).
REQ-026 frames_sent SHALL wrap from 16'hFFFF to 0.
REQ-027 ack, tx_start and frame_done SHALL never be high for more than one consecutive cycle.
REQ-028 Payload changes on data_in after GRANT SHALL NOT affect the frame in progress.

Reset
REQ-029 On rst_n low, all outputs SHALL go immediately to: ack=0, tx_start=0, tx_byte=8'h00, busy=0, frame_done=0, frames_sent=0.
REQ-030 On rst_n low, the state SHALL go to IDLE, byte index to 0, and last_grant to NCH-1, so that channel 0 has first priority.
REQ-031 Reset mid-frame SHALL abort the frame with no frame_done; the partial frame SHALL NOT be resent.

Verification
REQ-032 req=4'b0100, data ch2=16'h1234, tx_ready=1, tx_done after each start -> ack=4'b0100 once; bytes AA,07,02,12,34,89; frame_done once; frames_sent=1.
REQ-033 req=4'b1111 held, all channels served back-to-back -> grant order 0,1,2,3,0; each ack precedes exactly 6 tx_start pulses.
REQ-034 tx_ready held low 10 cycles in SEND -> no tx_start for those cycles, tx_byte stable; first tx_start comes on the cycle tx_ready rises.
REQ-035 rst_n pulsed low after byte 3 -> outputs at reset values; next req=4'b0001 yields a full frame starting AA, with channel 0 first.
REQ-036 Spurious tx_done in IDLE/SEND, and req dropped before GRANT -> no state change, no ack, no byte.
REQ-037 Force frames_sent=16'hFFFF and complete one frame -> frames_sent=16'h0000, frame_done=1 for one cycle.

Source files
------------

// File: rtl/uart_frame_sched.sv
// uart_frame_sched: round-robin frame builder in front of a byte UART TX.
// Frame = HDR0 HDR1 chan pay_hi pay_lo xor.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   req[NCH]            level requests, held until ack
//   data_in[16*NCH]     per-channel payloads
//   ack[NCH]            one-cycle grant pulse
//   tx_ready, tx_done   byte transmitter handshake in
//   tx_start, tx_byte   byte launch out
//   busy                state != IDLE
//   frame_done          pulse after the last byte's tx_done
//   frames_sent         completed frame count (wraps)
module uart_frame_sched #(
  parameter int          NCH  = 4,
  parameter logic [7:0]  HDR0 = 8'hAA,
  parameter logic [7:0]  HDR1 = 8'h07
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NCH-1:0]     req,
  input  logic [16*NCH-1:0]  data_in,
  output logic [NCH-1:0]     ack,
  input  logic               tx_ready,
  input  logic               tx_done,
  output logic               tx_start,
  output logic [7:0]         tx_byte,
  output logic               busy,
  output logic               frame_done,
  output logic [15:0]        frames_sent
);

  localparam int IW = $clog2(NCH);

  typedef enum logic [1:0] {
    IDLE, GRANT, SEND, WAIT
  } state_t;

  state_t          state;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   ch_q;
  logic [IW-1:0]   win;
  logic [15:0]     pay_q;
  logic [2:0]      byte_idx;
  logic [2:0]      nxt_idx;
  logic [7:0]      nxt_byte;
  logic [7:0]      ch_byte;
  logic [7:0]      csum;
  logic [15:0]     pay_arr [NCH];

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      pay_arr[i] = data_in[16*i +: 16];
    end
  end

  // Rotated priority: first requester after last_grant wins.
  always_comb begin
    logic          hit;
    logic [IW-1:0] ci;
    int            c;
    win = last_grant;
    hit = 1'b0;
    ci  = '0;
    c   = 0;
    for (int k = 1; k <= NCH; k++) begin
      c  = (int'(last_grant) + k) % NCH;
      ci = IW'(c);
      if (!hit && req[ci]) begin
        hit = 1'b1;
        win = ci;
      end
    end
  end

  assign ch_byte = {{(8-IW){1'b0}}, ch_q};
  assign csum    = HDR0 ^ HDR1 ^ ch_byte
                 ^ pay_q[15:8] ^ pay_q[7:0];
  assign nxt_idx = byte_idx + 3'd1;

  always_comb begin
    nxt_byte = csum;
    unique case (nxt_idx)
      3'd1:    nxt_byte = HDR1;
      3'd2:    nxt_byte = ch_byte;
      3'd3:    nxt_byte = pay_q[15:8];
      3'd4:    nxt_byte = pay_q[7:0];
      default: nxt_byte = csum;
    endcase
  end

  // tx_byte is loaded on entry to SEND, so the
  // launch itself can follow tx_ready directly.
  assign tx_start = (state == SEND) && tx_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ack         <= '0;
      tx_byte     <= 8'h00;
      frame_done  <= 1'b0;
      frames_sent <= 16'h0000;
      byte_idx    <= 3'd0;
      last_grant  <= IW'(NCH-1);
      ch_q        <= '0;
      pay_q       <= 16'h0000;
    end else begin
      ack        <= '0;
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|req) begin
            ack   <= NCH'(1) << win;
            ch_q  <= win;
            state <= GRANT;
          end
        end
        GRANT: begin
          pay_q      <= pay_arr[ch_q];
          last_grant <= ch_q;
          byte_idx   <= 3'd0;
          tx_byte    <= HDR0;
          state      <= SEND;
        end
        SEND: begin
          if (tx_ready) state <= WAIT;
        end
        WAIT: begin
          if (tx_done) begin
            if (byte_idx == 3'd5) begin
              state       <= IDLE;
              frame_done  <= 1'b1;
              frames_sent <= frames_sent + 16'd1;
            end else begin
              byte_idx <= nxt_idx;
              tx_byte  <= nxt_byte;
              state    <= SEND;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_sched.sv
// tb_uart_frame_sched: directed scoreboard bench
// for the round-robin UART frame scheduler.
module tb_uart_frame_sched;

  localparam int NCH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NCH-1:0]   req = '0;
  logic [16*NCH-1:0] data_in = '0;
  logic [NCH-1:0]   ack;
  logic             tx_ready = 1'b1;
  logic             tx_done;
  logic             td_m = 1'b0;
  logic             td_s = 1'b0;
  logic             tx_start;
  logic [7:0]       tx_byte;
  logic             busy;
  logic             frame_done;
  logic [15:0]      frames_sent;

  assign tx_done = td_m | td_s;

  uart_frame_sched #(.NCH(NCH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .data_in     (data_in),
    .ack         (ack),
    .tx_ready    (tx_ready),
    .tx_done     (tx_done),
    .tx_start    (tx_start),
    .tx_byte     (tx_byte),
    .busy        (busy),
    .frame_done  (frame_done),
    .frames_sent (frames_sent)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int n_start = 0;
  int n_ack = 0;
  int n_fd = 0;
  int st_since = 0;
  bit had_ack = 1'b0;
  bit auto_tx = 1'b1;
  logic pa = 1'b0;
  logic pt = 1'b0;
  logic pf = 1'b0;
  logic [7:0] bq[$];
  int gq[$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int ch,
                            input logic [15:0] p);
    logic [7:0] b [6];
    b[0] = 8'hAA;
    b[1] = 8'h07;
    b[2] = 8'(ch);
    b[3] = p[15:8];
    b[4] = p[7:0];
    b[5] = b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4];
    foreach (b[i]) bq.push_back(b[i]);
  endtask

  task automatic wait_ack(input int n, input int budget);
    int got = 0;
    for (int i = 0; i < budget && got < n; i++) begin
      @(negedge clk);
      if (|ack) got++;
    end
    chk("ack_wait", 32'(got), 32'(n));
  endtask

  task automatic wait_fd(input int target, input int budget);
    for (int i = 0; i < budget && n_fd < target; i++) step();
    chk("fd_wait", 32'(n_fd), 32'(target));
  endtask

  // Monitor: scoreboard pops and pulse-width checks.
  always @(negedge clk) begin
    chk("pulse_width",
        32'({pa & (|ack), pt & tx_start, pf & frame_done}),
        32'h0);
    pa <= |ack;
    pt <= tx_start;
    pf <= frame_done;
    if (!rst_n) begin
      st_since <= 0;
      had_ack  <= 1'b0;
    end
    if (|ack) begin
      n_ack++;
      chk("ack_expected", 32'(gq.size() != 0), 32'h1);
      if (gq.size() != 0)
        chk("ack_chan", 32'(ack), 32'(1) << gq.pop_front());
      if (had_ack)
        chk("starts_per_frame", 32'(st_since), 32'd6);
      had_ack  <= 1'b1;
      st_since <= 0;
    end
    if (tx_start) begin
      n_start++;
      st_since <= st_since + 1;
      chk("byte_expected", 32'(bq.size() != 0), 32'h1);
      if (bq.size() != 0)
        chk("tx_byte", 32'(tx_byte), 32'(bq.pop_front()));
    end
    if (frame_done) n_fd++;
  end

  // Byte transmitter model: tx_done one cycle into WAIT.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start && auto_tx) begin
        step();
        td_m = 1'b1;
        step();
        td_m = 1'b0;
      end
    end
  end

  initial begin
    int base;
    int f0;

    data_in[16*0 +: 16] = 16'hBEEF;
    data_in[16*1 +: 16] = 16'h0F0F;
    data_in[16*2 +: 16] = 16'h1234;
    data_in[16*3 +: 16] = 16'hA5C3;

    // Reset values.
    step();
    step();
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_tx_start", 32'(tx_start), 32'h0);
    chk("rst_tx_byte", 32'(tx_byte), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_frame_done", 32'(frame_done), 32'h0);
    chk("rst_frames_sent", 32'(frames_sent), 32'h0);
    rst_n = 1'b1;
    step();

    // All channels requesting: order 0,1,2,3,0.
    gq.push_back(0);
    gq.push_back(1);
    gq.push_back(2);
    gq.push_back(3);
    gq.push_back(0);
    push_frame(0, 16'hBEEF);
    push_frame(1, 16'h0F0F);
    push_frame(2, 16'h1234);
    push_frame(3, 16'hA5C3);
    push_frame(0, 16'hBEEF);
    req = 4'b1111;
    wait_ack(5, 400);
    step();
    req = 4'b0000;
    wait_fd(5, 200);
    chk("rr_frames_sent", 32'(frames_sent), 32'd5);
    chk("rr_starts", 32'(n_start), 32'd30);
    chk("rr_acks", 32'(n_ack), 32'd5);

    // Single channel 2 frame; payload changes after grant.
    base = n_start;
    gq.push_back(2);
    bq.push_back(8'hAA);
    bq.push_back(8'h07);
    bq.push_back(8'h02);
    bq.push_back(8'h12);
    bq.push_back(8'h34);
    bq.push_back(8'h89);
    req = 4'b0100;
    wait_ack(1, 50);
    step();
    req = 4'b0000;
    data_in[16*2 +: 16] = 16'hFFFF;
    wait_fd(6, 200);
    chk("ch2_frames_sent", 32'(frames_sent), 32'd6);
    chk("ch2_starts", 32'(n_start - base), 32'd6);
    chk("ch2_acks", 32'(n_ack), 32'd6);

    // tx_ready low for 10 cycles in SEND, spurious tx_done there.
    tx_ready = 1'b0;
    gq.push_back(3);
    push_frame(3, 16'hA5C3);
    req = 4'b1000;
    wait_ack(1, 50);
    step();
    req = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      chk("stall_tx_start", 32'(tx_start), 32'h0);
      chk("stall_tx_byte", 32'(tx_byte), 32'hAA);
      chk("stall_busy", 32'(busy), 32'h1);
      td_s = (i == 4);
      step();
    end
    td_s = 1'b0;
    tx_ready = 1'b1;
    #1;
    chk("ready_rise_start", 32'(tx_start), 32'h1);
    wait_fd(7, 200);
    chk("stall_frames_sent", 32'(frames_sent), 32'd7);

    // Spurious tx_done in IDLE and a req glitch between edges.
    base = n_start;
    f0 = n_ack;
    td_s = 1'b1;
    step();
    td_s = 1'b0;
    req = 4'b0001;
    #2;
    req = 4'b0000;
    step();
    step();
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_no_ack", 32'(n_ack - f0), 32'h0);
    chk("idle_no_start", 32'(n_start - base), 32'h0);

    // Reset mid-frame after the third byte.
    base = n_start;
    f0 = n_fd;
    gq.push_back(1);
    bq.push_back(8'hAA);
    bq.push_back(8'h07);
    bq.push_back(8'h01);
    req = 4'b0010;
    for (int i = 0; i < 100 && n_start < base + 3; i++) step();
    chk("abort_starts", 32'(n_start - base), 32'd3);
    rst_n = 1'b0;
    req = 4'b0000;
    #1;
    chk("mid_rst_ack", 32'(ack), 32'h0);
    chk("mid_rst_tx_start", 32'(tx_start), 32'h0);
    chk("mid_rst_tx_byte", 32'(tx_byte), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_frame_done", 32'(frame_done), 32'h0);
    chk("mid_rst_frames_sent", 32'(frames_sent), 32'h0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("abort_no_fd", 32'(n_fd - f0), 32'h0);
    chk("abort_bq_empty", 32'(bq.size()), 32'h0);
    gq.push_back(0);
    gq.push_back(1);
    push_frame(0, 16'hBEEF);
    push_frame(1, 16'h0F0F);
    req = 4'b0011;
    wait_ack(1, 50);
    step();
    req = 4'b0010;
    wait_ack(1, 100);
    step();
    req = 4'b0000;
    wait_fd(f0 + 2, 200);
    chk("post_rst_frames_sent", 32'(frames_sent), 32'd2);

    // frames_sent wrap.
    force dut.frames_sent = 16'hFFFF;
    step();
    release dut.frames_sent;
    step();
    chk("forced_count", 32'(frames_sent), 32'hFFFF);
    f0 = n_fd;
    gq.push_back(2);
    push_frame(2, 16'hFFFF);
    req = 4'b0100;
    wait_ack(1, 50);
    step();
    req = 4'b0000;
    wait_fd(f0 + 1, 200);
    chk("wrap_frames_sent", 32'(frames_sent), 32'h0);
    chk("wrap_fd_low", 32'(frame_done), 32'h0);

    step();
    chk("end_bq_empty", 32'(bq.size()), 32'h0);
    chk("end_gq_empty", 32'(gq.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
